// File: rtl/handshake_rx_sync.sv
// Clocked receive end of a four-phase bundled-data micropipeline: synchronises req_in,
// captures data into a show-ahead FIFO, returns ack_out. Optional checker: HANDSHAKE_RX_PROTO_CHECK_EN.
module handshake_rx_sync #(
    parameter int DATA_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ack_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CW-1:0]         count,
    output logic                  proto_err
);

    typedef enum logic {IDLE, ACK_HI} state_t;

    state_t                              state;
    logic [SYNC_STAGES-1:0]              sync_q;
    logic                                req_s;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem;
    logic [AW-1:0]                       wr_ptr;
    logic [AW-1:0]                       rd_ptr;
    logic                                full;
    logic                                wr_en;
    logic                                rd_en;

    // req_in is asynchronous: only the last synchroniser flop feeds the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end

    assign req_s   = sync_q[SYNC_STAGES-1];
    assign full    = (count == CW'(DEPTH));
    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];
    assign wr_en   = (state == IDLE) && req_s && !full;
    assign rd_en   = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ack_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_s && !full) begin
                    state   <= ACK_HI;
                    ack_out <= 1'b1;
                end
                ACK_HI: if (!req_s) begin
                    state   <= IDLE;
                    ack_out <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ack_out <= 1'b0;
                end
            endcase
        end
    end

    // Full is judged on the pre-edge count, so a same-edge read never frees room for a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef HANDSHAKE_RX_PROTO_CHECK_EN
    logic                  req_s_d;
    logic                  stall_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  stall;

    assign stall = (state == IDLE) && req_s && full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_s_d   <= 1'b0;
            stall_q   <= 1'b0;
            data_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            req_s_d <= req_s;
            stall_q <= stall;
            data_q  <= data_in;
            if ((state == ACK_HI && req_s && !req_s_d) ||
                (stall && stall_q && data_in != data_q))
                proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: doc/handshake_rx_sync.md
Name: handshake_rx_sync

Overview:
- Clocked receiving end of the four-phase bundled-data req/ack micropipeline.
- Takes the pipeline's output request and data, synchronises the request into the clk domain, captures the data into a small local FIFO, and returns the acknowledge.
- Presents captured words on a valid/ready stream.
- Sits between the asynchronous pipeline tail and synchronous consumer logic.

Parameters:
- DATA_WIDTH, 3, width of the bundled data word.
- SYNC_STAGES, 2, flops in the req_in synchroniser; legal range 2..4.
- DEPTH, 4, local FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  1  four-phase request from the pipeline (asynchronous to clk).
- data_in  input  DATA_WIDTH  bundled data; stable while req_in is high.
- ack_out  output  1  four-phase acknowledge back to the pipeline.
- m_valid  output  1  FIFO non-empty; m_data holds the head word.
- m_ready  input  1  consumer accepts the head word when m_valid and m_ready are both high at a clk edge.
- m_data  output  DATA_WIDTH  FIFO head word (show-ahead).
- count  output  clog2(DEPTH+1)  current FIFO occupancy.
- proto_err  output  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Reset (async assert, clk-sync release):
  - ack_out=0, m_valid=0, m_data=0, count=0, proto_err=0.
  - Synchroniser flops = 0, pointers = 0, FSM = IDLE.
- Synchroniser: req_s is req_in delayed through SYNC_STAGES flops. Nothing else samples req_in directly.
- FSM (registered ack_out):
  - IDLE (ack_out=0):
    - If req_s=1 and count<DEPTH: write data_in to FIFO tail at this edge, set ack_out=1, go to ACK_HI.
    - If req_s=1 and the FIFO is full: stay in IDLE and withhold ack. This is the backpressure path; no data is lost.
  - ACK_HI (ack_out=1): when req_s=0, clear ack_out and go to IDLE. Otherwise hold.
- Latency:
  - req_in rise to ack_out rise: SYNC_STAGES+1 clk edges when the FIFO is not full.
  - req_in fall to ack_out fall: SYNC_STAGES+1 edges.
  - Captured word is visible on m_data/m_valid one edge after capture.
- Data capture: data_in is sampled only on the IDLE->ACK_HI edge. The synchroniser delay provides the bundled-data settling margin.
- FIFO:
  - Circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH.
  - Read occurs when m_valid & m_ready; rd_ptr advances.
  - Simultaneous write and read in one edge: count unchanged, both pointers advance.
  - Full case: a write is never attempted while count==DEPTH. A read on that same edge does not enable a same-edge write; the write happens on the next edge.
  - Empty case: m_ready with m_valid=0 is ignored and the pointers do not move.
- m_data reflects the head entry; its value when m_valid=0 is don't-care but stable.
- Reset mid-handshake:
  - ack_out drops asynchronously and FIFO contents are discarded.
  - If req_in is still high after release, the FSM treats it as a fresh request after SYNC_STAGES+1 edges.
- Only one handshake is outstanding at a time. A req_in rise while ack_out=1 is a protocol violation.

Optional Feature:
- Macro: HANDSHAKE_RX_PROTO_CHECK_EN.
- Defined:
  - In ACK_HI, a req_s rise without an intervening fall sets proto_err=1 (sticky until rst). Detection uses the rising edge of req_s.
  - In IDLE with req_s=1, a data_in change on consecutive clk samples while waiting on a full FIFO also sets proto_err=1 (sticky until rst).
- Undefined: proto_err tied 0; no checking logic synthesised.

Test Plan:
- Single transfer, SYNC_STAGES=2, m_ready=1: req_in=1 with data_in=3'd5 -> ack_out=1 at edge 3; m_valid=1, m_data=5 next edge; req_in=0 -> ack_out=0 three edges later; count returns to 0.
- Burst of 4 words (1,2,3,4), m_ready=0 -> count=4; a fifth request (data 6) gets no ack; raise m_ready -> ack for 6 arrives; outputs read 1,2,3,4,6 in order.
- Wrap-around: 10 transfers with m_ready toggling 1/0 -> all 10 words delivered in order; count never exceeds DEPTH.
- Simultaneous read and write at count=2 -> count stays 2 and data order is preserved.
- rst pulsed while ack_out=1 and count=3 -> ack_out=0, m_valid=0, count=0 immediately; req_in held high -> new ack after 3 edges with the current data_in captured.
- HANDSHAKE_RX_PROTO_CHECK_EN defined, data_in changed from 2 to 7 while stalled on full FIFO -> proto_err=1, held until rst. Without the macro -> proto_err stays 0.
